ask_tx_scheduler: RTL and testbench

Frame-level controller for the ASK transmit datapath. It accepts payload bytes over a valid/ready handshake and sequences each frame as preamble, payload and guard. It slices the payload into 1/2/3-bit symbols at the configured symbol rate. It drives the data converter's mixer mode and symbol level, and gates the DDS carrier, replacing free-running serial data and button-selected mode with framed, flow-controlled transmission.

---
 rtl/ask_tx_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_ask_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ask_tx_scheduler.sv
// Framed ASK transmit controller: preamble / payload / guard sequencing,
// 10-bit payload bit buffer sliced into 1..3-bit symbols, DDS and mixer gating.
module ask_tx_scheduler #(
    parameter int SYM_DIV       = 5000,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GUARD_SYMS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg_mode,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       busy,
    output logic [1:0] mixer_mode,
    output logic [2:0] sym_level,
    output logic       sym_strobe,
    output logic       dds_run,
    output logic       underrun,
    output logic       frame_done
);

    localparam int DIV_W   = $clog2(SYM_DIV);
    localparam int CNT_MAX = (PREAMBLE_SYMS > GUARD_SYMS) ? PREAMBLE_SYMS : GUARD_SYMS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_GUARD} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [9:0]       buf_q, buf_d;
    logic [3:0]       buf_cnt_q, buf_cnt_d;
    logic             last_seen_q, last_seen_d;
    logic             busy_q, busy_d;
    logic             s_ready_q, s_ready_d;
    logic [1:0]       mixer_mode_q, mixer_mode_d;
    logic [2:0]       sym_level_q, sym_level_d;
    logic             sym_strobe_q, sym_strobe_d;
    logic             underrun_q, underrun_d;
    logic             frame_done_q, frame_done_d;

    logic       boundary, accept, pay_eval;
    logic [1:0] bps;
    logic [2:0] top_lvl;
    logic [3:0] pop_n, rem_cnt;
    logic [9:0] rem_buf;

    function automatic logic [2:0] max_of(input logic [1:0] m);
        return 3'((4'd1 << m) - 4'd1);
    endfunction

    // Mode code equals bits per symbol; bits below buf_cnt are always zero,
    // so the top bps bits are already the zero-padded tail on the last pop.
    assign bps     = mode_q;
    assign top_lvl = buf_q[9:7] >> (2'd3 - bps);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        mode_d       = mode_q;
        buf_d        = buf_q;
        buf_cnt_d    = buf_cnt_q;
        last_seen_d  = last_seen_q;
        sym_level_d  = sym_level_q;
        sym_strobe_d = 1'b0;
        underrun_d   = 1'b0;
        frame_done_d = 1'b0;
        pay_eval     = 1'b0;
        pop_n        = 4'd0;
        rem_cnt      = 4'd0;
        rem_buf      = 10'd0;
        boundary     = (div_cnt_q == DIV_W'(SYM_DIV - 1));
        accept       = s_valid && s_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start && cfg_mode != 2'b00) begin
                    state_d      = ST_PREAMBLE;
                    mode_d       = cfg_mode;
                    buf_d        = 10'd0;
                    buf_cnt_d    = 4'd0;
                    last_seen_d  = 1'b0;
                    div_cnt_d    = '0;
                    sym_cnt_d    = '0;
                    sym_level_d  = max_of(cfg_mode);
                    sym_strobe_d = 1'b1;
                end
            end
            default: begin
                if (boundary) begin
                    div_cnt_d    = '0;
                    sym_strobe_d = 1'b1;
                    case (state_q)
                        ST_PREAMBLE: begin
                            if (sym_cnt_q == CNT_W'(PREAMBLE_SYMS - 1)) begin
                                pay_eval = 1'b1;
                            end else begin
                                sym_cnt_d   = sym_cnt_q + 1'b1;
                                sym_level_d = sym_cnt_q[0] ? max_of(mode_q) : 3'd0;
                            end
                        end
                        ST_PAYLOAD: pay_eval = 1'b1;
                        default: begin
                            sym_level_d = 3'd0;
                            if (sym_cnt_q == CNT_W'(GUARD_SYMS - 1)) begin
                                state_d      = ST_IDLE;
                                sym_cnt_d    = '0;
                                sym_strobe_d = 1'b0;
                                frame_done_d = 1'b1;
                            end else begin
                                sym_cnt_d = sym_cnt_q + 1'b1;
                            end
                        end
                    endcase
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase

        if (pay_eval) begin
            state_d   = ST_PAYLOAD;
            sym_cnt_d = '0;
            if (buf_cnt_q >= {2'b00, bps}) begin
                sym_level_d = top_lvl;
                pop_n       = {2'b00, bps};
            end else if (last_seen_q && buf_cnt_q != 4'd0) begin
                sym_level_d = top_lvl;
                pop_n       = buf_cnt_q;
            end else if (last_seen_q) begin
                state_d     = ST_GUARD;
                sym_level_d = 3'd0;
            end else begin
                sym_level_d = 3'd0;
                underrun_d  = 1'b1;
            end
        end

        // Pop first, then append the accepted byte behind what remains.
        if (state_q != ST_IDLE) begin
            rem_buf = buf_q << pop_n;
            rem_cnt = buf_cnt_q - pop_n;
            if (accept) begin
                buf_d     = rem_buf | ({s_data, 2'b00} >> rem_cnt);
                buf_cnt_d = rem_cnt + 4'd8;
                if (s_last) last_seen_d = 1'b1;
            end else begin
                buf_d     = rem_buf;
                buf_cnt_d = rem_cnt;
            end
        end

        busy_d       = (state_d != ST_IDLE);
        mixer_mode_d = busy_d ? mode_d : 2'b00;
        s_ready_d    = (state_d == ST_PREAMBLE || state_d == ST_PAYLOAD) &&
                       (buf_cnt_d <= 4'd2) && !last_seen_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            mode_q       <= 2'b00;
            buf_q        <= 10'd0;
            buf_cnt_q    <= 4'd0;
            last_seen_q  <= 1'b0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            mixer_mode_q <= 2'b00;
            sym_level_q  <= 3'd0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            mode_q       <= mode_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            last_seen_q  <= last_seen_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
            mixer_mode_q <= mixer_mode_d;
            sym_level_q  <= sym_level_d;
            sym_strobe_q <= sym_strobe_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign dds_run    = busy_q;
    assign mixer_mode = mixer_mode_q;
    assign sym_level  = sym_level_q;
    assign sym_strobe = sym_strobe_q;
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ask_tx_scheduler.sv
// Bench for ask_tx_scheduler: frames are predicted symbol-by-symbol from the
// byte stream, mode and underrun count, then compared cycle by cycle.
module tb_ask_tx_scheduler;

    localparam int SYM_DIV = 4;
    localparam int PRE     = 2;
    localparam int GUARD   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_mode;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       busy;
    logic [1:0] mixer_mode;
    logic [2:0] sym_level;
    logic       sym_strobe;
    logic       dds_run;
    logic       underrun;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0]  pay [8];
    logic [10:0] all_outs;

    assign all_outs = {s_ready, busy, dds_run, mixer_mode, sym_level, sym_strobe, underrun, frame_done};

    always #5 clk = ~clk;

    ask_tx_scheduler #(
        .SYM_DIV      (SYM_DIV),
        .PREAMBLE_SYMS(PRE),
        .GUARD_SYMS   (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .busy      (busy),
        .mixer_mode(mixer_mode),
        .sym_level (sym_level),
        .sym_strobe(sym_strobe),
        .dds_run   (dds_run),
        .underrun  (underrun),
        .frame_done(frame_done)
    );

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); cfg_mode = 2'($urandom); s_data = 8'($urandom);
            s_valid = 1'($urandom); s_last = 1'($urandom);
            @(negedge clk);
            checks++;
            if (all_outs !== 11'd0) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %b expected all zero", i, all_outs);
            end
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'($urandom); s_data = 8'($urandom); s_last = 1'($urandom);
            cfg_mode = 2'($urandom);
            @(negedge clk);
            checks++;
            if (all_outs !== 11'd0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: got %b expected all zero (s_ready low)", i, all_outs);
            end
        end
    endtask

    task automatic test_ignored_off();
        s_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (all_outs !== 11'd0) begin
                errors++;
                $display("FAIL start_mode_off cycle %0d: got %b expected all zero", i, all_outs);
            end
        end
    endtask

    // One complete frame: model predicts every symbol level from the rules,
    // then each cycle's outputs are compared against that timeline.
    task automatic test_frame(input string name, input logic [1:0] mode, input int nb,
                              input int k_und, input bit bubbles, input bit noise);
        int   bps, maxl, total, nsym, sym, idx, v, last_cyc;
        int   exp_lv[$];
        bit   stb, und, rel_ok, bub, prev_bub, acc_now, acc_prev, last_done;
        logic [9:0] exp_v, got_v;

        bps  = int'(mode);
        maxl = (1 << bps) - 1;
        for (int i = 0; i < PRE; i++) exp_lv.push_back((i % 2 == 0) ? maxl : 0);
        for (int i = 0; i < k_und; i++) exp_lv.push_back(0);
        total = 8 * nb;
        for (int p = 0; p < total; p += bps) begin
            v = 0;
            for (int j = 0; j < bps; j++)
                v = (v << 1) | ((p + j < total) ? int'(pay[(p + j) / 8][7 - ((p + j) % 8)]) : 0);
            exp_lv.push_back(v);
        end
        for (int i = 0; i < GUARD; i++) exp_lv.push_back(0);
        nsym     = exp_lv.size();
        last_cyc = 1 + SYM_DIV * nsym;

        @(negedge clk);
        start = 1'b1; cfg_mode = mode; s_valid = 1'b0; s_last = 1'b0;
        idx = 0; prev_bub = 1'b0; acc_prev = 1'b0; last_done = 1'b0;

        for (int rel = 1; rel <= last_cyc + 2; rel++) begin
            @(negedge clk);
            start = 1'b0;
            if (rel < last_cyc) begin
                sym   = (rel - 1) / SYM_DIV;
                stb   = ((rel - 1) % SYM_DIV == 0);
                und   = stb && sym >= PRE && sym < PRE + k_und;
                exp_v = {1'b1, 1'b1, mode, 3'(exp_lv[sym]), stb, und, 1'b0};
            end else if (rel == last_cyc) begin
                exp_v = 10'b0000000001;
            end else begin
                exp_v = 10'd0;
            end
            got_v = {busy, dds_run, mixer_mode, sym_level, sym_strobe, underrun, frame_done};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s rel %0d busy/dds/mode/lvl/stb/und/done: got %b expected %b",
                         name, rel, got_v, exp_v);
            end
            if (rel == 1) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s s_ready_first: got %b expected 1", name, s_ready);
                end
            end else if (rel >= last_cyc || last_done || acc_prev) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s s_ready_low rel %0d: got %b expected 0", name, rel, s_ready);
                end
            end

            rel_ok = (k_und == 0) || (rel >= 1 + SYM_DIV * (PRE + k_und - 1));
            bub    = bubbles && !prev_bub && ($urandom_range(0, 2) == 0);
            acc_now = 1'b0;
            if (idx < nb && rel_ok && !bub && rel < last_cyc) begin
                s_valid = 1'b1; s_data = pay[idx]; s_last = (idx == nb - 1);
                acc_now = (s_ready === 1'b1);
                if (acc_now) begin
                    if (s_last) last_done = 1'b1;
                    idx++;
                end
            end else begin
                s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
            end
            prev_bub = bub;
            acc_prev = acc_now;
            if (noise) begin
                cfg_mode = 2'($urandom);
                if (busy === 1'b1) start = ($urandom_range(0, 3) == 0);
            end
        end
        start = 1'b0; s_valid = 1'b0;
        checks++;
        if (idx !== nb) begin
            errors++;
            $display("FAIL %s bytes_consumed: got %0d expected %0d", name, idx, nb);
        end
    endtask

    task automatic test_rst_mid_payload();
        @(negedge clk);
        start = 1'b1; cfg_mode = 2'b10; s_valid = 1'b0;
        @(negedge clk);                       // first preamble cycle, buffer empty
        start = 1'b0; s_valid = 1'b1; s_data = 8'h1B; s_last = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (12) @(negedge clk);           // two payload symbols in, 4 bits left
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_inframe: got busy %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (all_outs !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b expected all zero", all_outs);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (all_outs !== 11'd0) begin
                errors++;
                $display("FAIL rst_mid_quiet cycle %0d: got %b expected all zero", i, all_outs);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        int nb, k;
        for (int f = 0; f < 8; f++) begin
            m  = 2'($urandom_range(1, 3));
            nb = $urandom_range(1, 4);
            k  = $urandom_range(0, 2);
            for (int i = 0; i < nb; i++) pay[i] = 8'($urandom);
            test_frame($sformatf("rand%0d", f), m, nb, k, 1'b1, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_mode = 2'b00; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        test_reset();
        test_ignored_off();
        pay[0] = 8'hA5;
        test_frame("2ask_a5", 2'b01, 1, 0, 1'b0, 1'b0);
        pay[0] = 8'hFF; pay[1] = 8'h00;
        test_frame("8ask_ff00", 2'b11, 2, 0, 1'b0, 1'b0);
        pay[0] = 8'h1B;
        test_frame("4ask_underrun", 2'b10, 1, 2, 1'b0, 1'b0);
        test_rst_mid_payload();
        pay[0] = 8'h3C;
        test_frame("restart_after_rst", 2'b10, 1, 0, 1'b0, 1'b0);
        pay[0] = 8'h96; pay[1] = 8'h5A;
        test_frame("mid_frame_noise", 2'b01, 2, 1, 1'b0, 1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
